// File: rtl/day10_machine_scheduler_pkg.sv
// Day 10 machine scheduler: shared widths and sequencer state encoding.
// Width defaults match the day 10 reader and button-press solver.
package day10_machine_scheduler_pkg;

  localparam int DEF_MAX_NUM_BUTTONS = 13;
  localparam int DEF_MAX_NUM_LIGHTS  = 10;
  localparam int DEF_PRESS_W  = $clog2(DEF_MAX_NUM_BUTTONS + 1);
  localparam int DEF_LIGHTS_W = $clog2(DEF_MAX_NUM_LIGHTS + 1);
  localparam int DEF_SUM_W    = 32;
  localparam int DEF_CNT_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    KICK_READ,
    WAIT_READ,
    KICK_SOLVE,
    WAIT_SOLVE,
    ACCUM,
    DONE
  } sched_state_t;

endpackage

// File: rtl/day10_machine_scheduler_if.sv
// Day 10 machine scheduler: control, reader, solver and result bundle.
// master = scheduler side, slave = reader/solver/consumer side.
interface day10_machine_scheduler_if #(
  parameter int LIGHTS_W = 4,
  parameter int PRESS_W  = 4,
  parameter int SUM_W    = 32,
  parameter int CNT_W    = 16
);

  logic                start;
  logic                reader_start;
  logic                reader_ready;
  logic                end_of_input;
  logic [LIGHTS_W-1:0] num_lights;
  logic                solver_start;
  logic                solver_done;
  logic [PRESS_W-1:0]  solver_presses;
  logic                solver_unsolvable;
  logic                busy;
  logic                result_valid;
  logic                result_ready;
  logic [SUM_W-1:0]    result;
  logic [CNT_W-1:0]    machine_count;
  logic [CNT_W-1:0]    unsolvable_count;
  logic                overflow;

  modport master (
    input  start,
    output reader_start,
    input  reader_ready,
    input  end_of_input,
    input  num_lights,
    output solver_start,
    input  solver_done,
    input  solver_presses,
    input  solver_unsolvable,
    output busy,
    output result_valid,
    input  result_ready,
    output result,
    output machine_count,
    output unsolvable_count,
    output overflow
  );

  modport slave (
    output start,
    input  reader_start,
    output reader_ready,
    output end_of_input,
    output num_lights,
    input  solver_start,
    output solver_done,
    output solver_presses,
    output solver_unsolvable,
    input  busy,
    input  result_valid,
    output result_ready,
    input  result,
    input  machine_count,
    input  unsolvable_count,
    input  overflow
  );

endinterface

// File: rtl/day10_machine_scheduler_sat_accumulator.sv
// Saturating accumulator: clamps at all-ones on carry-out and
// raises a sticky overflow flag until the next clear.
module day10_machine_scheduler_sat_accumulator #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_add_en,
  input  logic [W-1:0] i_add_val,
  output logic [W-1:0] o_sum,
  output logic         o_overflow
);

  logic [W-1:0] r_sum;
  logic         r_ovf;
  logic [W:0]   w_ext;

  assign w_ext = {1'b0, r_sum} + {1'b0, i_add_val};

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_sum <= '0;
      r_ovf <= 1'b0;
    end else if (i_add_en) begin
      if (w_ext[W]) begin
        r_sum <= '1;
        r_ovf <= 1'b1;
      end else begin
        r_sum <= w_ext[W-1:0];
      end
    end
  end

  assign o_sum      = r_sum;
  assign o_overflow = r_ovf;

endmodule

// File: rtl/day10_machine_scheduler.sv
// Day 10 top sequencer: reads each machine, runs the solver on it,
// and accumulates minimum press counts into a held result.
module day10_machine_scheduler
  import day10_machine_scheduler_pkg::*;
#(
  parameter int PRESS_W  = DEF_PRESS_W,
  parameter int LIGHTS_W = DEF_LIGHTS_W,
  parameter int SUM_W    = DEF_SUM_W,
  parameter int CNT_W    = DEF_CNT_W
) (
  input logic clk,
  input logic rst_n,
  day10_machine_scheduler_if.master bus
);

  sched_state_t r_state;
  sched_state_t w_next;

  logic [PRESS_W-1:0] r_presses;
  logic               r_unsolv;
  logic [CNT_W-1:0]   r_mcount;
  logic [CNT_W-1:0]   r_ucount;

  logic             w_clr;
  logic             w_accum;
  logic             w_no_lights;
  logic             w_rd_hit;
  logic             w_sv_hit;
  logic [SUM_W-1:0] w_add;
  logic [SUM_W-1:0] w_sum;
  logic             w_ovf;

  assign w_clr       = (r_state == IDLE) && bus.start;
  assign w_accum     = (r_state == ACCUM);
  assign w_no_lights = (bus.num_lights == LIGHTS_W'(0));
  assign w_rd_hit    = (r_state == WAIT_READ) && bus.reader_ready;
  assign w_sv_hit    = (r_state == WAIT_SOLVE) && bus.solver_done;
  assign w_add       = r_unsolv ? '0 : SUM_W'(r_presses);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:       if (bus.start) w_next = KICK_READ;
      KICK_READ:  w_next = WAIT_READ;
      WAIT_READ: begin
        if (bus.reader_ready) begin
          w_next = w_no_lights ? ACCUM : KICK_SOLVE;
        end
      end
      KICK_SOLVE: w_next = WAIT_SOLVE;
      WAIT_SOLVE: if (bus.solver_done) w_next = ACCUM;
      ACCUM:      w_next = bus.end_of_input ? DONE : KICK_READ;
      DONE:       if (bus.result_ready) w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end

  // A light-less machine is trivially solved with zero presses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presses <= '0;
      r_unsolv  <= 1'b0;
      r_mcount  <= '0;
      r_ucount  <= '0;
    end else begin
      if (w_clr) begin
        r_mcount <= '0;
        r_ucount <= '0;
      end
      if (w_rd_hit && w_no_lights) begin
        r_presses <= '0;
        r_unsolv  <= 1'b0;
      end
      if (w_sv_hit) begin
        r_presses <= bus.solver_presses;
        r_unsolv  <= bus.solver_unsolvable;
      end
      if (w_accum) begin
        if (r_mcount != '1) r_mcount <= r_mcount + 1'b1;
        if (r_unsolv && (r_ucount != '1)) r_ucount <= r_ucount + 1'b1;
      end
    end
  end

  day10_machine_scheduler_sat_accumulator #(
    .W(SUM_W)
  ) u_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_clr),
    .i_add_en   (w_accum),
    .i_add_val  (w_add),
    .o_sum      (w_sum),
    .o_overflow (w_ovf)
  );

  // Gating with rst_n keeps pulses quiet in the reset cycle itself.
  assign bus.reader_start = rst_n && (r_state == KICK_READ);
  assign bus.solver_start = rst_n && (r_state == KICK_SOLVE);
  assign bus.busy         = rst_n && (r_state != IDLE) && (r_state != DONE);
  assign bus.result_valid = rst_n && (r_state == DONE);

  assign bus.result           = w_sum;
  assign bus.machine_count    = r_mcount;
  assign bus.unsolvable_count = r_ucount;
  assign bus.overflow         = w_ovf;

endmodule
